// File: rtl/rompack_pkg.sv
// Shared types and constants for the ROM-pack loader.
package rompack_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} rp_state_t;

  localparam logic [7:0] ROM_FILL   = 8'hFF;
  localparam int         ROM_ADDR_W = 15;

endpackage

// File: rtl/rompack_ram.sv
// ROM-pack storage: one write port, one registered read port, single clock.
module rompack_ram
  import rompack_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // No reset on purpose: contents survive reset, and rdata holds between reads.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rompack_loader.sv
// Loads the .rmm ROM-pack image from hps_io and serves PMD85 ROM-module reads.
// Optional running byte checksum output: define ROMPACK_CHECKSUM_EN.
module rompack_loader
  import rompack_pkg::*;
#(
  parameter int          ADDR_W    = ROM_ADDR_W,
  parameter logic [7:0]  ROM_INDEX = 8'd1,
  parameter logic [17:0] LED_HOLD  = 18'd184320
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_rd,
  output logic [7:0]        rom_data,
  output logic              rom_valid,
  output logic              loaded,
  output logic [ADDR_W:0]   image_size,
  output logic              overflow,
`ifdef ROMPACK_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic              LED_YELLOW
);

  rp_state_t       state_reg, state_next;
  logic [ADDR_W:0] cnt_reg;
  logic [ADDR_W:0] image_size_reg;
  logic            loaded_reg;
  logic            overflow_reg;
  logic [17:0]     led_cnt_reg;
  logic            rom_valid_reg;
  logic            use_mem_reg;
  logic [7:0]      ram_q;

  logic            sel;
  logic            enter_load;
  logic            finish;
  logic            wr_evt;
  logic            in_range;
  logic            ram_we;
  logic            rd_en;
  logic            use_mem_next;
  logic [ADDR_W:0] addr_inc;

  assign sel      = ioctl_download & (ioctl_index == ROM_INDEX);
  assign in_range = (ioctl_addr[24:ADDR_W] == '0);
  assign addr_inc = {1'b0, ioctl_addr[ADDR_W-1:0]} + {{ADDR_W{1'b0}}, 1'b1};
  assign ram_we   = wr_evt & in_range;

  always_comb begin
    state_next = state_reg;
    enter_load = 1'b0;
    finish     = 1'b0;
    wr_evt     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel) begin
          state_next = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        wr_evt = ioctl_wr & sel;
        if (!sel) state_next = FINISH;
      end
      FINISH: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A read returns memory only for a settled, complete image; the write owns the port on a clash.
  assign rd_en        = rom_rd & ~ram_we;
  assign use_mem_next = (state_reg == IDLE) & loaded_reg & ~ram_we &
                        ({1'b0, rom_addr} < image_size_reg);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      image_size_reg <= '0;
      loaded_reg     <= 1'b0;
      overflow_reg   <= 1'b0;
      led_cnt_reg    <= '0;
      rom_valid_reg  <= 1'b0;
      use_mem_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rom_valid_reg <= rom_rd;
      if (rom_rd) use_mem_reg <= use_mem_next;

      if (enter_load) begin
        loaded_reg   <= 1'b0;
        overflow_reg <= 1'b0;
        cnt_reg      <= '0;
      end
      if (wr_evt) begin
        if (!in_range)            overflow_reg <= 1'b1;
        else if (addr_inc > cnt_reg) cnt_reg   <= addr_inc;
      end
      if (finish) begin
        image_size_reg <= cnt_reg;
        loaded_reg     <= (cnt_reg != '0);
      end

      if (wr_evt)                 led_cnt_reg <= LED_HOLD;
      else if (led_cnt_reg != '0) led_cnt_reg <= led_cnt_reg - 18'd1;
    end
  end

`ifdef ROMPACK_CHECKSUM_EN
  logic [15:0] checksum_reg;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)        checksum_reg <= '0;
    else if (enter_load) checksum_reg <= '0;
    else if (ram_we)     checksum_reg <= checksum_reg + {8'h00, ioctl_dout};
  end

  assign checksum = checksum_reg;
`endif

  rompack_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk_sys),
    .we    (ram_we),
    .waddr (ioctl_addr[ADDR_W-1:0]),
    .wdata (ioctl_dout),
    .re    (rd_en),
    .raddr (rom_addr),
    .rdata (ram_q)
  );

  assign rom_data   = use_mem_reg ? ram_q : ROM_FILL;
  assign rom_valid  = rom_valid_reg;
  assign loaded     = loaded_reg;
  assign image_size = image_size_reg;
  assign overflow   = overflow_reg;
  assign LED_YELLOW = (led_cnt_reg != '0) | (state_reg == LOAD);

endmodule
